eeprom_ctrl: RTL and testbench
==============================

Name: eeprom_ctrl

Overview:
Sequencing controller in front of the EEPROM macro (4-bit address, 8-bit data, we, erase_enable, combinational read). It accepts one host request at a time (READ, ERASE or WRITE) through a valid/ready handshake. For WRITE it performs erase-before-program, holds each strobe for its programmed duration, and read-back-verifies the result. It returns one response per request with read data and an error flag.

Parameters:
ADDR_W, 4, EEPROM address width
DATA_W, 8, EEPROM data width
ERASE_CYCLES, 4, cycles erase_enable is held per erase (>=1)
WRITE_CYCLES, 4, cycles we is held per program (>=1)
ERASED_VAL, 8'hFF, value an erased location reads back; must match the EEPROM instance

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_op  in  2  2'b00 READ, 2'b01 ERASE, 2'b10 WRITE, 2'b11 illegal
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data (WRITE only)
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_rdata  out  DATA_W  read data / verify read-back value
rsp_err  out  1  verify mismatch or illegal op
busy  out  1  state != IDLE
ee_addr  out  ADDR_W  to EEPROM addr
ee_we  out  1  to EEPROM we
ee_erase_enable  out  1  to EEPROM erase_enable
ee_write_data  out  DATA_W  to EEPROM write_data
ee_data  in  DATA_W  from EEPROM data (combinational read)

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, ee_addr=0, ee_we=0, ee_erase_enable=0, ee_write_data=0, counter=0.
- States: IDLE, READ, ERASE, PROG, VERIFY, RESP. All outputs are registered or decoded from state only; no combinational path from req_* to ee_*.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op/addr/wdata. Next state: READ (op 00), ERASE (op 01 or 10), RESP with rsp_err=1 and rsp_rdata=0 (op 11, no EEPROM strobe).
- ee_addr = latched addr in every non-IDLE state. ee_addr=0 in IDLE.
- READ: 1 cycle. Capture ee_data into rsp_rdata at the end of the cycle. rsp_err=0. Go to RESP.
- ERASE: ee_erase_enable=1 for exactly ERASE_CYCLES cycles (down-counter). Then go to PROG if op=WRITE, else VERIFY with expected=ERASED_VAL.
- PROG: ee_we=1 and ee_write_data=latched wdata for exactly WRITE_CYCLES cycles. ee_write_data=0 outside PROG. Then go to VERIFY with expected=wdata.
- VERIFY: 1 cycle, no strobes. Capture ee_data into rsp_rdata. rsp_err=(ee_data!=expected). Go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE. req_ready=1 again on the following cycle; there is no same-cycle turnaround.
- Invariant: ee_we and ee_erase_enable are never high in the same cycle. Neither strobe is high in IDLE, READ, VERIFY or RESP.
- Latency, accept edge to first rsp_valid cycle: READ 2, ERASE ERASE_CYCLES+2, WRITE ERASE_CYCLES+WRITE_CYCLES+2, illegal 1.
- req_valid while busy is ignored (req_ready=0); the host must hold the request.
- rst mid-operation: on the next edge all strobes drop, state goes to IDLE, and the pending response is discarded. The EEPROM location content is then undefined. rst has priority over every other event.
- Counter width $clog2(max(ERASE_CYCLES,WRITE_CYCLES))+1. ERASE_CYCLES=1 and WRITE_CYCLES=1 are legal and give single-cycle strobes.

Test Plan:
- Reset, then READ addr 3 with EEPROM preloaded 8'h5A -> rsp_valid 2 cycles after accept, rsp_rdata=8'h5A, rsp_err=0, no strobe seen.
- WRITE addr 2 data 8'hAA -> ee_erase_enable high exactly 4 cycles, then ee_we high exactly 4 cycles with ee_write_data=8'hAA, ee_addr=2 throughout, response at cycle 10 with rsp_rdata=8'hAA, rsp_err=0. A following READ addr 2 returns 8'hAA.
- ERASE addr 5 -> erase_enable 4 cycles, rsp_rdata=8'hFF, rsp_err=0. With a bench model forcing a stuck bit (reads 8'hFB) -> rsp_err=1, rsp_rdata=8'hFB.
- Back-to-back: WRITE 8 8'hCC, then WRITE 15 8'hDD held valid during busy -> second accepted only after first response handshake. Hold rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0.
- req_op=2'b11 -> response 1 cycle after accept with rsp_err=1, rsp_rdata=0, ee_we and ee_erase_enable never asserted.
- Assert rst during cycle 2 of PROG -> next edge ee_we=0, busy=0, req_ready=1, rsp_valid=0. A new READ then completes normally.

Source files
------------

// File: rtl/eeprom_ctrl.sv
// Request sequencer in front of a small EEPROM macro: reads, erases, and
// writes as erase-then-program with a read-back verify, one request at a time.
module eeprom_ctrl #(
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       ERASE_CYCLES = 4,
    parameter int unsigned       WRITE_CYCLES = 4,
    parameter logic [DATA_W-1:0] ERASED_VAL   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ee_addr,
    output logic              ee_we,
    output logic              ee_erase_enable,
    output logic [DATA_W-1:0] ee_write_data,
    input  logic [DATA_W-1:0] ee_data
);

    localparam int unsigned MAX_CYC =
        (ERASE_CYCLES > WRITE_CYCLES) ? ERASE_CYCLES : WRITE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StErase,
        StProg,
        StVerify,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A plain ERASE verifies against the erased pattern, a WRITE against its data.
    assign expected = (op_q == OP_WRITE) ? wdata_q : ERASED_VAL;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    case (req_op)
                        OP_READ: state_d = StRead;
                        OP_ERASE, OP_WRITE: begin
                            state_d = StErase;
                            cnt_d   = CNT_W'(ERASE_CYCLES - 1);
                        end
                        default: begin
                            state_d = StResp;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StRead: begin
                rdata_d = ee_data;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StErase: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_WRITE) begin
                        state_d = StProg;
                        cnt_d   = CNT_W'(WRITE_CYCLES - 1);
                    end else begin
                        state_d = StVerify;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StProg: begin
                if (cnt_q == '0) begin
                    state_d = StVerify;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVerify: begin
                rdata_d = ee_data;
                err_d   = (ee_data != expected);
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready       = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign rsp_valid       = (state_q == StResp);
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign ee_addr         = (state_q == StIdle) ? '0 : addr_q;
    assign ee_erase_enable = (state_q == StErase);
    assign ee_we           = (state_q == StProg);
    assign ee_write_data   = (state_q == StProg) ? wdata_q : '0;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Bench for eeprom_ctrl: behavioural EEPROM with a stuck-bit mask, a table of
// requests scored through a response queue, and hand-written corner sequences.
module tb_eeprom_ctrl;

    localparam int LIMIT = 200;

    typedef struct {
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] mask;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         lat;
        int         n_er;
        int         n_we;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic [3:0] ee_addr;
    logic       ee_we;
    logic       ee_erase_enable;
    logic [7:0] ee_write_data;
    logic [7:0] ee_data;

    logic [7:0] mem [16];
    logic       mem_init;
    logic [7:0] stuck_mask;
    logic [3:0] cur_addr;
    logic [7:0] cur_wdata;
    int         er_tot = 0;
    int         we_tot = 0;
    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q [$];
    logic [8:0] sb_e;
    vec_t       vecs [10];

    always #5 clk = ~clk;

    eeprom_ctrl #(
        .ADDR_W       (4),
        .DATA_W       (8),
        .ERASE_CYCLES (4),
        .WRITE_CYCLES (4),
        .ERASED_VAL   (8'hFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .ee_addr         (ee_addr),
        .ee_we           (ee_we),
        .ee_erase_enable (ee_erase_enable),
        .ee_write_data   (ee_write_data),
        .ee_data         (ee_data)
    );

    // EEPROM model; the mask emulates bits stuck at zero on read.
    assign ee_data = mem[ee_addr] & stuck_mask;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 8'h5A : 8'h00;
        end else if (ee_erase_enable) begin
            mem[ee_addr] <= 8'hFF;
        end else if (ee_we) begin
            mem[ee_addr] <= ee_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (ee_we && ee_erase_enable) begin
                errors++;
                $display("FAIL strobe_overlap: we and erase_enable both high (t=%0t)", $time);
            end
            if (ee_erase_enable) er_tot++;
            if (ee_we) begin
                we_tot++;
                chk("ee_write_data", 32'(ee_write_data), 32'(cur_wdata));
            end else begin
                chk("ee_write_data_idle", 32'(ee_write_data), 32'(0));
            end
            if (busy) chk("ee_addr", 32'(ee_addr), 32'(cur_addr));
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rsp: rdata %0h err %0b with empty queue",
                         rsp_rdata, rsp_err);
            end else begin
                sb_e = sb_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(sb_e[8:1]));
                chk("rsp_err", 32'(rsp_err), 32'(sb_e[0]));
            end
        end
    end

    task automatic timeout(input string name);
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
    endtask

    task automatic do_req(input vec_t v);
        int n;
        int lat;
        int er0;
        int we0;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_op     = v.op;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        stuck_mask = v.mask;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("req_accept");
            req_valid = 1'b0;
            return;
        end
        cur_addr  = v.addr;
        cur_wdata = v.wdata;
        er0 = er_tot;
        we0 = we_tot;
        sb_q.push_back({v.exp_rdata, v.exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.lat));
        @(posedge clk);
        #1;
        stuck_mask = 8'hFF;
        chk("erase_cycles", 32'(er_tot - er0), 32'(v.n_er));
        chk("we_cycles", 32'(we_tot - we0), 32'(v.n_we));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{2'b00, 4'd3, 8'h00, 8'hFF, 8'h5A, 1'b0, 2, 0, 0};
        vecs[1] = '{2'b10, 4'd2, 8'hAA, 8'hFF, 8'hAA, 1'b0, 10, 4, 4};
        vecs[2] = '{2'b00, 4'd2, 8'h00, 8'hFF, 8'hAA, 1'b0, 2, 0, 0};
        vecs[3] = '{2'b01, 4'd5, 8'h00, 8'hFF, 8'hFF, 1'b0, 6, 4, 0};
        vecs[4] = '{2'b01, 4'd5, 8'h00, 8'hFB, 8'hFB, 1'b1, 6, 4, 0};
        vecs[5] = '{2'b11, 4'd7, 8'h12, 8'hFF, 8'h00, 1'b1, 1, 0, 0};
        vecs[6] = '{2'b10, 4'd9, 8'h55, 8'hFF, 8'h55, 1'b0, 10, 4, 4};
        vecs[7] = '{2'b00, 4'd9, 8'h00, 8'hFF, 8'h55, 1'b0, 2, 0, 0};
        vecs[8] = '{2'b10, 4'd4, 8'h0F, 8'hFB, 8'h0B, 1'b1, 10, 4, 4};
        vecs[9] = '{2'b00, 4'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 2, 0, 0};

        rst        = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = 4'd0;
        req_wdata  = 8'h00;
        rsp_ready  = 1'b1;
        stuck_mask = 8'hFF;
        cur_addr   = 4'd0;
        cur_wdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ee_addr", 32'(ee_addr), 32'(0));
        chk("rst_ee_we", 32'(ee_we), 32'(0));
        chk("rst_ee_erase", 32'(ee_erase_enable), 32'(0));

        for (int i = 0; i < 10; i++) do_req(vecs[i]);

        // Back-to-back writes with the second held during busy, plus a response stall.
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 4'd8;
        req_wdata = 8'hCC;
        @(negedge clk);
        chk("b2b_first_ready", 32'(req_ready), 32'(1));
        cur_addr  = 4'd8;
        cur_wdata = 8'hCC;
        sb_q.push_back({8'hCC, 1'b0});
        @(posedge clk);
        #1;
        req_addr  = 4'd15;
        req_wdata = 8'hDD;
        @(negedge clk);
        chk("b2b_busy_ready", 32'(req_ready), 32'(0));
        n = 0;
        while (!rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("b2b_first_rsp");
        for (int k = 0; k < 3; k++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("stall_rsp_rdata", 32'(rsp_rdata), 32'(8'hCC));
            chk("stall_req_ready", 32'(req_ready), 32'(0));
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second_ready", 32'(req_ready), 32'(1));
        chk("b2b_first_done", 32'(sb_q.size()), 32'(0));
        cur_addr  = 4'd15;
        cur_wdata = 8'hDD;
        sb_q.push_back({8'hDD, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("b2b_second_rsp");
        @(posedge clk);
        #1;

        // Reset in the second PROG cycle; the pending response is dropped.
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 4'd6;
        req_wdata = 8'h33;
        @(negedge clk);
        chk("rstprog_ready", 32'(req_ready), 32'(1));
        cur_addr  = 4'd6;
        cur_wdata = 8'h33;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ee_we && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!ee_we) timeout("rstprog_wait_we");
        @(negedge clk);
        chk("rstprog_we_cycle2", 32'(ee_we), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstprog_we", 32'(ee_we), 32'(0));
        chk("rstprog_erase", 32'(ee_erase_enable), 32'(0));
        chk("rstprog_busy", 32'(busy), 32'(0));
        chk("rstprog_req_ready", 32'(req_ready), 32'(1));
        chk("rstprog_rsp_valid", 32'(rsp_valid), 32'(0));
        rst = 1'b0;
        do_req(vecs[0]);

        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
